mod_i2c_slave: RTL and testbench
================================

MOD_I2C_SLAVE -- requirements
Module: mod_I2C_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50: 7-bit address this target answers to.
REQ-002 clk  input  1  system clock, 16 MHz.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 SCL  input  1  I2C clock from the controller.
REQ-006 SDA  inout  1  I2C data, open drain: driven 0 or high-Z only, never 1.
REQ-007 txData  input  8  byte returned on a read; sampled when txReq pulses.
REQ-008 rxData  output  8  last byte received in a write.
REQ-009 rxValid  output  1  one-clk pulse when rxData updates.
REQ-010 txReq  output  1  one-clk pulse when txData is loaded into the shift register.
REQ-011 busy  output  1  high from address match until STOP, NACK-end or reset.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized values plus one extra delayed copy.
REQ-013 START = synced SDA falls while synced SCL high; STOP = synced SDA rises while synced SCL high.
REQ-014 States: IDLE, ADDR, ADDR_ACK, WRITE, DATA_ACK, READ, READ_ACK.
REQ-015 START from any state SHALL clear the bit counter and enter ADDR (repeated start included); SDA released the same cycle.
REQ-016 STOP from any state SHALL enter IDLE, release SDA and clear busy.
REQ-017 Bits SHALL be sampled on detected SCL rising edges and driven/changed only on detected SCL falling edges, MSB first.
REQ-018 ADDR: shift 8 bits (7 address + R/W); after the 8th rising edge, on address match go to ADDR_ACK and set busy, else go to IDLE and never drive SDA until the next START.
REQ-019 ADDR_ACK: drive SDA=0 from the next SCL falling edge to the following falling edge; at that release edge go to WRITE (R/W=0) or READ (R/W=1).
REQ-020 Entering READ (and every re-entry): load txData into the shift register and pulse txReq in the same clk cycle as the releasing falling edge; drive bit 7 immediately.
REQ-021 WRITE: on the 8th rising edge, update rxData and pulse rxValid in the cycle after detection; go to DATA_ACK.
REQ-022 DATA_ACK: drive SDA=0 for one SCL low-high-low period as in REQ-019, then return to WRITE for the next byte.
REQ-023 READ: after the 8th bit's falling edge release SDA and go to READ_ACK.
REQ-024 READ_ACK: sample SDA on the rising edge; 0 (ACK) -> READ at the next falling edge; 1 (NACK) -> IDLE, busy low, SDA released.
REQ-025 Bit counter SHALL be 4 bits, count 0..8, and clear on every state entry; no wrap beyond 8.
REQ-026 The rxValid and txReq pulses SHALL be exactly one clk wide and never coincide.
REQ-027 SCL edges arriving in IDLE without a START SHALL be ignored.

Reset
REQ-028 rst high SHALL force, on the next clk edge: state IDLE, SDA high-Z, rxData=0, rxValid=0, txReq=0, busy=0, counters and shift register 0, synchronizer flops 1; this holds even mid-byte or mid-ACK.
REQ-029 After rst falls, the block SHALL ignore the bus until a fresh START.

Verification
REQ-030 Write 0xA0 then 0xA5 at 100 kHz -> ACK on both bytes, rxData=0xA5, one rxValid pulse, busy high until STOP.
REQ-031 Address 0xA2 (addr 0x51) -> SDA never driven low, no rxValid, busy stays 0.
REQ-032 Read 0xA1 with txData=0x3C, controller NACK -> ACK on address, SDA bits 0,0,1,1,1,1,0,0, one txReq pulse, then IDLE and busy=0.
REQ-033 Read two bytes (ACK then NACK) with txData 0x81 then 0x7E -> two txReq pulses, correct bits on SDA for both bytes.
REQ-034 Write 0xA0, repeated START, read 0xA1 -> ADDR re-entered, read completes correctly.
REQ-035 rst asserted during the DATA_ACK low-drive -> SDA released next clk, state IDLE, next transfer succeeds.

Source files
------------

// File: rtl/mod_i2c_slave.sv
// mod_i2c_slave: I2C target with a 7-bit address and one-byte rx/tx handshake.
// SCL/SDA are oversampled on clk; every bus action is keyed off synchronized
// SCL edges, and SDA is only ever pulled low or released (open drain).
module mod_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] txData,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       txReq,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        DATA_ACK,
        READ,
        READ_ACK
    } state_t;

    state_t     state;
    logic [2:0] scl_sync;   // [0],[1] synchronizer, [2] delayed copy for edges
    logic [2:0] sda_sync;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       rw;
    logic       sda_low;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall;
    logic start_det, stop_det;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    // START/STOP: SDA edge while SCL is high
    assign start_det = scl_s & ~sda_sync[1] & sda_sync[2];
    assign stop_det  = scl_s & sda_sync[1] & ~sda_sync[2];

    // Open-drain pad: pull low or float, never drive high
    assign SDA = sda_low ? 1'b0 : 1'bz;

    // Two-flop synchronizers plus one delayed stage; idle bus level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[1:0], SCL};
            sda_sync <= {sda_sync[1:0], SDA};
        end
    end

    // Protocol FSM: bits sampled on SCL rise, SDA changed only on SCL fall
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            rw      <= 1'b0;
            sda_low <= 1'b0;
            rxData  <= '0;
            rxValid <= 1'b0;
            txReq   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            txReq   <= 1'b0;
            if (start_det) begin
                // Repeated START keeps busy; the address phase decides again
                state   <= ADDR;
                bit_cnt <= '0;
                sda_low <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // SCL activity without a START is not ours
                        sda_low <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_s};
                            if (bit_cnt == 4'd7) begin
                                // byte = {shift[6:0], sda_s}: address then R/W
                                bit_cnt <= '0;
                                if (shift[6:0] == SLAVE_ADDR) begin
                                    state <= ADDR_ACK;
                                    busy  <= 1'b1;
                                    rw    <= sda_s;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ADDR_ACK, DATA_ACK: begin
                        // First fall starts the ACK low, second fall ends it
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_low <= 1'b1;
                                bit_cnt <= 4'd1;
                            end else begin
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    state   <= READ;
                                    shift   <= txData;
                                    txReq   <= 1'b1;
                                    sda_low <= ~txData[7];
                                end else begin
                                    state   <= WRITE;
                                    sda_low <= 1'b0;
                                end
                            end
                        end
                    end

                    WRITE: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_s};
                            if (bit_cnt == 4'd7) begin
                                rxData  <= {shift[6:0], sda_s};
                                rxValid <= 1'b1;
                                state   <= DATA_ACK;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    READ: begin
                        // bit_cnt = bits already clocked out to the controller
                        if (scl_rise && bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                state   <= READ_ACK;
                                bit_cnt <= '0;
                            end else begin
                                sda_low <= ~shift[3'd7 - bit_cnt[2:0]];
                            end
                        end
                    end

                    READ_ACK: begin
                        // bit_cnt==1 marks an ACK seen, next fall reloads
                        if (scl_rise) begin
                            if (sda_s) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= READ;
                            bit_cnt <= '0;
                            shift   <= txData;
                            txReq   <= 1'b1;
                            sda_low <= ~txData[7];
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        sda_low <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_i2c_slave.sv
// tb_mod_i2c_slave: bit-banged I2C controller driving the target, with a
// transaction-level expectation of acks, received bytes and pulse counts.
module tb_mod_i2c_slave;

    localparam logic [6:0] ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    mod_i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_bus), .txData(tx_data),
        .rxData(rx_data), .rxValid(rx_valid), .txReq(tx_req), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bus monitor: pulse counts, pulse shape, and target pulling SDA low
    int   rx_cnt = 0, tx_cnt = 0, drv_cnt = 0;
    logic pulse_bad = 1'b0, rxv_q = 1'b0, txr_q = 1'b0;
    always @(posedge clk) begin
        rxv_q <= rx_valid;
        txr_q <= tx_req;
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if ((rx_valid && rxv_q) || (tx_req && txr_q) || (rx_valid && tx_req))
            pulse_bad <= 1'b1;
        if (sda_bus === 1'b0 && !sda_low) drv_cnt <= drv_cnt + 1;
    end

    // Watchdog so the run always terminates
    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    int n_vec = 0, n_err = 0;
    int qclk = 40;   // clk per quarter SCL period: 160 clk/bit = 100 kHz at 16 MHz
    logic [7:0] xd [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n = 1);
        repeat (n * qclk) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; wq(); scl = 1'b1; wq(); sda_low = 1'b1; wq(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        scl = 1'b0; sda_low = 1'b1; wq(); scl = 1'b1; wq(); sda_low = 1'b0; wq();
    endtask

    task automatic put_bit(input logic b);
        wq(); sda_low = !b; wq(); scl = 1'b1; wq(2); scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        sda_low = 1'b0; wq(2); scl = 1'b1; wq(); b = sda_bus; wq(); scl = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    // next_tx is presented before the ACK bit so the following load sees it
    task automatic get_byte(output logic [7:0] d, input logic nack, input logic [7:0] next_tx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        tx_data = next_tx;
        put_bit(nack);
    endtask

    // One complete transaction checked against what an I2C target must do
    task automatic run_xfer(input string tag, input logic [6:0] a, input logic rw, input int n);
        logic       ack, exp_match;
        logic [7:0] d;
        int rx0, tx0, drv0;
        exp_match = (a == ADDR);
        rx0 = rx_cnt; tx0 = tx_cnt; drv0 = drv_cnt;
        if (rw) tx_data = xd[0];
        i2c_start();
        put_byte({a, rw}, ack);
        chk({tag, "_addr_ack"}, 32'(ack), 32'(!exp_match));
        if (!exp_match) begin
            i2c_stop();
            chk({tag, "_no_drive"}, 32'(drv_cnt - drv0), 32'd0);
            chk({tag, "_no_rx"}, 32'(rx_cnt - rx0), 32'd0);
            chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
            return;
        end
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                put_byte(xd[i], ack);
                chk({tag, "_data_ack"}, 32'(ack), 32'd0);
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_rxdata"}, 32'(rx_data), 32'(xd[n-1]));
            chk({tag, "_rxvalid_cnt"}, 32'(rx_cnt - rx0), 32'(n));
        end else begin
            for (int i = 0; i < n; i++) begin
                get_byte(d, (i == n - 1), (i < 3) ? xd[i+1] : 8'h00);
                chk({tag, "_rd_byte"}, 32'(d), 32'(xd[i]));
            end
            chk({tag, "_txreq_cnt"}, 32'(tx_cnt - tx0), 32'(n));
            chk({tag, "_busy_nack"}, 32'(busy), 32'd0);
        end
        i2c_stop();
        chk({tag, "_busy_stop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         tx0;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rxdata", 32'(rx_data), 32'd0);
        chk("rst_rxvalid", 32'(rx_valid), 32'd0);
        chk("rst_txreq", 32'(tx_req), 32'd0);
        chk("rst_sda", 32'(sda_bus), 32'd1);
        rst = 1'b0;
        wq(2);

        // Write 0xA5 to address 0x50
        xd[0] = 8'hA5;
        run_xfer("wr_a5", ADDR, 1'b0, 1);

        // Wrong address 0x51
        run_xfer("addr_51", 7'h51, 1'b0, 1);

        // Single read 0x3C, controller NACK
        xd[0] = 8'h3C;
        run_xfer("rd_3c", ADDR, 1'b1, 1);

        // Two-byte read 0x81, 0x7E
        xd[0] = 8'h81; xd[1] = 8'h7E;
        run_xfer("rd_2b", ADDR, 1'b1, 2);

        // Write, repeated START, read
        tx0 = tx_cnt;
        i2c_start();
        put_byte({ADDR, 1'b0}, ack);
        chk("rs_wr_addr_ack", 32'(ack), 32'd0);
        put_byte(8'h5A, ack);
        chk("rs_wr_data_ack", 32'(ack), 32'd0);
        tx_data = 8'hC3;
        i2c_start();
        put_byte({ADDR, 1'b1}, ack);
        chk("rs_rd_addr_ack", 32'(ack), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        get_byte(d, 1'b1, 8'h00);
        chk("rs_rd_byte", 32'(d), 32'hC3);
        chk("rs_rxdata", 32'(rx_data), 32'h5A);
        chk("rs_txreq_cnt", 32'(tx_cnt - tx0), 32'd1);
        i2c_stop();
        chk("rs_busy_stop", 32'(busy), 32'd0);

        // Reset while the target holds the data ACK low
        i2c_start();
        put_byte({ADDR, 1'b0}, ack);
        chk("rstack_addr_ack", 32'(ack), 32'd0);
        for (int i = 7; i >= 0; i--) put_bit(1'(8'h66 >> i));
        sda_low = 1'b0;
        wq();
        chk("rstack_drive", 32'(sda_bus), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstack_release", 32'(sda_bus), 32'd1);
        chk("rstack_busy", 32'(busy), 32'd0);
        chk("rstack_rxdata", 32'(rx_data), 32'd0);
        wq(); scl = 1'b1; wq(2); scl = 1'b0;
        i2c_stop();
        xd[0] = 8'h33;
        run_xfer("post_rst", ADDR, 1'b0, 1);

        // Randomized transactions at a faster SCL
        qclk = 20;
        for (int t = 0; t < 6; t++) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            a  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : ADDR;
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 2);
            for (int i = 0; i < 4; i++) xd[i] = 8'($urandom);
            run_xfer("rand", a, rw, n);
        end

        chk("pulse_shape", 32'(pulse_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
